midori64_round_ctrl: RTL and testbench

Round controller and round-key generator for the shared (TI) Midori64 core. It sits directly upstream of the round-constant mux. It drives the 4-bit round index into the mux and takes back the 16-bit constant. From these it builds the per-round key shares RK_i = K_(i mod 2) ⊕ α_i and the whitening key WK = K0 ⊕ K1. It also sequences the state-register load and enable strobes for the datapath.

---
 rtl/midori64_round_ctrl.sv | 179 +++++++++++++++++
 tb/tb_midori64_round_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/midori64_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : midori64_round_ctrl
//  Purpose  : Round controller and round-key generator for the threshold-
//             implemented (shared) Midori64 core. Sequences the datapath
//             (load, per-round enable, final phase, done) and builds the
//             shared round keys RK_i = K_(i mod 2) ^ alpha_i and the
//             whitening key WK = K0 ^ K1 from a registered copy of the key.
//  Ports    : clk, rst         - clock / synchronous active-high reset
//             start            - run request, sampled only in IDLE
//             key_in           - shared key, share s at [128s +: 128],
//                                K0 = [127:64], K1 = [63:0] of each share
//             round_cnst       - alpha for the current round (from RC mux)
//             round            - round index to the RC mux
//             rk / wk          - round-key / whitening-key shares
//             state_load       - datapath loads plaintext ^ WK
//             state_en         - datapath captures round output
//             final_phase      - final S-layer + WK phase active
//                                ("final" is a reserved word)
//             busy / done      - activity flag / one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module midori64_round_ctrl #(
  parameter int N_SHARES  = 3,
  parameter int ROUND_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [128*N_SHARES-1:0] key_in,
  input  logic [15:0]             round_cnst,
  output logic [3:0]              round,
  output logic [64*N_SHARES-1:0]  rk,
  output logic [64*N_SHARES-1:0]  wk,
  output logic                    state_load,
  output logic                    state_en,
  output logic                    final_phase,
  output logic                    busy,
  output logic                    done
);

  localparam int             PH_W    = (ROUND_CYC > 1) ? $clog2(ROUND_CYC) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(ROUND_CYC - 1);
  localparam logic [3:0]     LAST_RND = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              round_q, round_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [128*N_SHARES-1:0] key_q,   key_d;

  logic                    w_ph_last;
  logic [63:0]             w_cnst_mix;

  assign w_ph_last = (phase_q == PH_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      phase_q <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      phase_q <= phase_d;
      key_q   <= key_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    phase_d = phase_q;
    key_d   = key_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'd0;
          phase_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        phase_d = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (w_ph_last) begin
          phase_d = '0;
          if (round_q == LAST_RND) begin
            // Round index 15 selects K1 and alpha_15 for the final phase.
            round_d = 4'd15;
            state_d = S_FINAL;
          end else begin
            round_d = round_q + 4'd1;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_FINAL: begin
        if (w_ph_last) begin
          phase_d = '0;
          state_d = S_DONE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DONE: begin
        round_d = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        round_d = 4'd0;
        phase_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control decodes (registered state only; no path from start)
  // --------------------------------------------------------------------------
  always_comb begin
    round       = round_q;
    state_load  = (state_q == S_LOAD);
    state_en    = ((state_q == S_ROUND) || (state_q == S_FINAL)) && w_ph_last;
    final_phase = (state_q == S_FINAL);
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
  end

  // Spread alpha onto cell LSBs: cell j (bits [63-4j -: 4]) takes
  // round_cnst[15-j], i.e. bit 4m receives round_cnst[m].
  always_comb begin
    w_cnst_mix = '0;
    for (int m = 0; m < 16; m++) begin
      w_cnst_mix[4*m] = round_cnst[m];
    end
  end

  // --------------------------------------------------------------------------
  // Key shares: constant is injected into share 0 only so the XOR of the
  // shares carries alpha exactly once.
  // --------------------------------------------------------------------------
  for (genvar s = 0; s < N_SHARES; s++) begin : g_share
    logic [63:0] w_k0;
    logic [63:0] w_k1;
    logic [63:0] w_base;

    assign w_k0   = key_q[128*s+64 +: 64];
    assign w_k1   = key_q[128*s    +: 64];
    assign w_base = round_q[0] ? w_k1 : w_k0;
    assign wk[64*s +: 64] = w_k0 ^ w_k1;

    if (s == 0) begin : g_cnst
      assign rk[64*s +: 64] = w_base ^ w_cnst_mix;
    end else begin : g_plain
      assign rk[64*s +: 64] = w_base;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_midori64_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_midori64_round_ctrl
//  Purpose  : Directed self-checking bench for midori64_round_ctrl
//             (N_SHARES=3, ROUND_CYC=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_midori64_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [383:0] key_in;
  logic [15:0]  round_cnst;
  logic [3:0]   round;
  logic [191:0] rk;
  logic [191:0] wk;
  logic         state_load;
  logic         state_en;
  logic         final_phase;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [127:0] key_ref = 128'h687ded3b3c85b3f35b1009863e2a8cbf;

  always #5 clk = ~clk;

  midori64_round_ctrl #(
    .N_SHARES (3),
    .ROUND_CYC(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .round_cnst (round_cnst),
    .round      (round),
    .rk         (rk),
    .wk         (wk),
    .state_load (state_load),
    .state_en   (state_en),
    .final_phase(final_phase),
    .busy       (busy),
    .done       (done)
  );

  // Stand-in RC mux: the two documented constants plus a filler pattern.
  always_comb begin
    case (round)
      4'd0:    round_cnst = 16'h15B3;
      4'd1:    round_cnst = 16'h78C0;
      default: round_cnst = {round, ~round, round, ~round};
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Share 0 = K ^ s1 ^ s2 with random s1, s2.
  task automatic set_key();
    logic [127:0] s1, s2;
    s1 = {$urandom, $urandom, $urandom, $urandom};
    s2 = {$urandom, $urandom, $urandom, $urandom};
    key_in = {s2, s1, key_ref ^ s1 ^ s2};
  endtask

  function automatic logic [63:0] xor3(input logic [191:0] v);
    return v[63:0] ^ v[127:64] ^ v[191:128];
  endfunction

  // One full run; k counts cycles after the accepting edge (LOAD is k=1).
  task automatic run(input bit hold, input bit pulse, input bit swap);
    logic [127:0] sh1;
    int           exp_rnd;
    sh1   = key_in[255:128];
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      if (k > 1) tick();
      if (pulse && !hold) start = (k == 30);
      if (swap && k == 3) key_in = ~key_in;
      exp_rnd = (k == 1) ? 0 : (k <= 61) ? (k - 2) / 4 : 15;
      chk("busy",       64'(busy),        64'(1));
      chk("state_load", 64'(state_load),  64'(k == 1));
      chk("state_en",   64'(state_en),    64'(k >= 5 && ((k - 5) % 4) == 0));
      chk("final",      64'(final_phase), 64'(k >= 62 && k <= 65));
      chk("done",       64'(done),        64'(k == 66));
      chk("round",      64'(round),       64'(exp_rnd));
      if (k == 1) begin
        chk("wk_xor",    xor3(wk),     64'h336de4bd02af3f4c);
        chk("wk_share1", wk[127:64],   sh1[127:64] ^ sh1[63:0]);
      end
      if (k == 2) begin
        chk("rk0_xor",    xor3(rk),    64'h687cec3a2c94b3e2);
        chk("rk0_share1", rk[127:64],  sh1[127:64]);
      end
      if (k == 6) begin
        chk("rk1_xor",    xor3(rk),    64'h5a0119862f2a8cbf);
        chk("rk1_share1", rk[127:64],  sh1[63:0]);
      end
      if (k == 66) chk("wk_xor_end", xor3(wk), 64'h336de4bd02af3f4c);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    key_in = '0;
    set_key();
    // Reset: held for two cycles, key_in present but must not leak in.
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy",  64'(busy),       64'(0));
    chk("rst_done",  64'(done),       64'(0));
    chk("rst_load",  64'(state_load), 64'(0));
    chk("rst_en",    64'(state_en),   64'(0));
    chk("rst_final", 64'(final_phase), 64'(0));
    chk("rst_round", 64'(round),      64'(0));
    chk("rst_wk0",   wk[63:0],        64'h0);
    chk("rst_wk1",   wk[127:64],      64'h0);
    chk("rst_wk2",   wk[191:128],     64'h0);
    chk("rst_rk0",   rk[63:0],        64'h0001010110110011);
    chk("rst_rk1",   rk[127:64],      64'h0);
    tick();
    chk("idle_busy", 64'(busy), 64'(0));

    // Plain run, then IDLE with key retained.
    run(1'b0, 1'b0, 1'b0);
    tick();
    chk("post_busy",  64'(busy),  64'(0));
    chk("post_done",  64'(done),  64'(0));
    chk("post_round", 64'(round), 64'(0));
    chk("post_wk",    xor3(wk),   64'h336de4bd02af3f4c);

    // Mid-run start pulse and mid-run key change.
    set_key();
    run(1'b0, 1'b1, 1'b1);
    set_key();
    tick();

    // start held high through DONE: next acceptance in the following IDLE.
    run(1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_idle_busy", 64'(busy),       64'(0));
    chk("b2b_idle_load", 64'(state_load), 64'(0));
    tick();
    chk("b2b_load",      64'(state_load), 64'(1));
    chk("b2b_busy",      64'(busy),       64'(1));
    start = 1'b0;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;

    // Reset during round 7 aborts without done.
    set_key();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 31; k++) tick();
    chk("pre_abort_round", 64'(round), 64'(7));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",  64'(busy),  64'(0));
    chk("abort_round", 64'(round), 64'(0));
    chk("abort_done",  64'(done),  64'(0));
    chk("abort_wk",    xor3(wk),   64'h0);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("abort_no_done", 64'(done | busy), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
